// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Produces stall/flush/forward controls, freezes the pipeline during data
// memory wait states (with timeout into a sticky fault), and keeps
// saturating stall/flush event counters for performance debug.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             regwriteE,
  input  logic [1:0]       wbselE,
  input  logic [4:0]       rdM,
  input  logic             regwriteM,
  input  logic [4:0]       rdW,
  input  logic             regwriteW,
  input  logic             pcselE,
  input  logic             memreqM,
  input  logic             mem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StWait, StFault} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic lu;
  logic branch;
  logic lu_stall;

  // Hazard detection; freeze is disabled in fault so the pipeline can drain.
  always_comb begin
    freeze   = memreqM & ~mem_ready & (state_q != StFault);
    lu       = regwriteE & (wbselE == 2'b00) & (rdE != 5'd0) &
               ((rdE == rs1D) | (rdE == rs2D));
    branch   = pcselE & ~freeze;
    lu_stall = lu & ~pcselE & ~freeze;
  end

  // Stall/flush/forward outputs, all forced low while reset is asserted.
  always_comb begin
    stallF    = rst_n & (freeze | lu_stall);
    stallD    = rst_n & (freeze | lu_stall);
    stallE    = rst_n & freeze;
    stallM    = rst_n & freeze;
    flushW    = rst_n & freeze;
    flushD    = rst_n & branch;
    flushE    = rst_n & (branch | lu_stall);
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    if (rst_n) begin
      // M stage holds the younger result, so it wins over W.
      if (regwriteM && rdM != 5'd0 && rdM == rs1E) begin
        forwardAE = 2'b10;
      end else if (regwriteW && rdW != 5'd0 && rdW == rs1E) begin
        forwardAE = 2'b01;
      end
      if (regwriteM && rdM != 5'd0 && rdM == rs2E) begin
        forwardBE = 2'b10;
      end else if (regwriteW && rdW != 5'd0 && rdW == rs2E) begin
        forwardBE = 2'b01;
      end
      forwardAD = regwriteW & (rdW != 5'd0) & (rdW == rs1D);
      forwardBD = regwriteW & (rdW != 5'd0) & (rdW == rs2D);
    end
  end

  // Memory-wait FSM next state and saturating counter updates.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StWait: begin
        if (mem_ready || !memreqM) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
          state_d   = StFault;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (stallF && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch && flush_cnt_q != {CNT_W{1'b1}}) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It drives the stall, flush and forwarding controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and feeds the decode stage's `flushE`. It also runs a small state machine that freezes the pipeline while the data memory inserts wait states, with a timeout and a fault state. Saturating stall and flush counters are provided for performance debug.

## Interface
- `TIMEOUT`, 16: maximum number of consecutive memory wait cycles before the block declares a fault (must be ≥ 2).
- `CNT_W`, 16: width of the performance counters.

- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1D`, `rs2D` in 5: source register indices of the instruction in decode.
- `rs1E`, `rs2E`, `rdE` in 5: source and destination indices in execute.
- `regwriteE` in 1: execute-stage register write enable.
- `wbselE` in 2: execute-stage writeback select; `00` means load.
- `rdM`, `regwriteM` in 5/1: memory-stage destination index and write enable.
- `rdW`, `regwriteW` in 5/1: writeback-stage destination index and write enable.
- `pcselE` in 1: branch taken or jump in execute.
- `memreqM` in 1: load or store in the memory stage.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `stallF`, `stallD` out 1: hold the PC and the IF/ID register.
- `stallE`, `stallM` out 1: hold the ID/EX and EX/MEM registers.
- `flushD`, `flushE`, `flushW` out 1: bubble the IF/ID, ID/EX and MEM/WB registers.
- `forwardAE`, `forwardBE` out 2: ALU operand source. `00` = register file, `01` = W result, `10` = M ALU result.
- `forwardAD`, `forwardBD` out 1: bypass `resultW` into the decode read data.
- `mem_err` out 1: sticky memory-timeout fault.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- **freeze** = `memreqM & ~mem_ready & (state != FAULT)`.
  - When high, `stallF`, `stallD`, `stallE`, `stallM` and `flushW` are all 1.
  - All other flushes are 0 while frozen. A taken branch is held in E and flushes only after release.
- **Load-use hazard (lu)** = `regwriteE & wbselE==00 & rdE!=0 & (rdE==rs1D | rdE==rs2D)`.
- **Priority** (highest first): freeze, then `pcselE`, then lu.
  - `pcselE` (not frozen): `flushD = flushE = 1`. No stall. This overrides lu.
  - lu (not frozen, no `pcselE`): `stallF = stallD = flushE = 1`.
- **forwardAE**:
  - `10` if `regwriteM & rdM!=0 & rdM==rs1E`.
  - Otherwise `01` if `regwriteW & rdW!=0 & rdW==rs1E`.
  - Otherwise `00`.
  - `forwardBE` is the same using `rs2E`.
  - M always beats W.
- **forwardAD** = `regwriteW & rdW!=0 & rdW==rs1D`. `forwardBD` is the same using `rs2D`.
- **FSM states**: RUN, WAIT, FAULT.
  - RUN → WAIT when freeze is high. `wait_cnt` loads 1.
  - WAIT → RUN when `mem_ready` or `~memreqM`. Otherwise `wait_cnt` increments.
  - WAIT → FAULT when still waiting and `wait_cnt == TIMEOUT-1`. `mem_err` is set on entry.
  - FAULT is absorbing until reset. Freeze is disabled so the pipeline drains; data is undefined.
- **Counters**:
  - `stall_cnt` increments in every cycle where `stallF` is 1.
  - `flush_cnt` increments in every cycle where `flushD | flushE` is 1 due to `pcselE`.
  - Both saturate at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and the FSM state: zero latency, same cycle.
- FSM state, `wait_cnt`, `mem_err` and the counters update on the rising edge.
- Reset (asynchronous, active-low) sets:
  - state = RUN, `wait_cnt` = 0, `mem_err` = 0, `stall_cnt` = `flush_cnt` = 0.
  - While `rst_n` is low, all stall and flush outputs are forced to 0 and all forward outputs are forced to 0.
- A freeze lasts exactly as many cycles as `memreqM & ~mem_ready` is high, up to `TIMEOUT` cycles. In the fault cycle the freeze is still asserted; it drops in the next cycle.
- `mem_ready` in the same cycle as `memreqM` gives zero freeze cycles and the FSM stays in RUN.
- Reset asserted mid-WAIT returns the FSM to RUN immediately.
- A load-use stall lasts one cycle: the inserted bubble clears the hazard condition in the next cycle.

## Test plan
- **Load-use bubble.** Drive `rdE=5`, `regwriteE=1`, `wbselE=00`, `rs1D=5` → `stallF=stallD=flushE=1` for exactly 1 cycle; `stall_cnt` goes 0→1.
- **Forward priority.** Drive `rs1E=3`, `rdM=3`/`regwriteM=1`, `rdW=3`/`regwriteW=1` → `forwardAE=10`. With `rdM=0`, `rs1E=0` → `forwardAE=00`.
- **Branch over load-use.** Set `pcselE=1` together with the lu condition → `flushD=flushE=1`, `stallF=0`; `flush_cnt` increments by 1.
- **Memory wait.** Hold `memreqM=1` with `mem_ready=0` for 3 cycles, then 1 → all four stalls and `flushW` high for 3 cycles; FSM goes RUN→WAIT→RUN; `mem_err=0`.
- **Timeout.** With `TIMEOUT=4`, hold `mem_ready=0` → freeze for 4 cycles, then `mem_err=1` and the stalls drop. `mem_err` stays 1 until `rst_n` pulses low.
- **Async reset mid-WAIT.** Pull `rst_n` low during WAIT → all outputs are 0 within the same cycle with no clock edge; the counters read 0.
